// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload (save) path.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } nv_state_t;

  localparam logic [7:0] NV_INDEX_DEFAULT = 8'hFF;
  localparam logic [7:0] NV_FILL          = 8'hFF;

endpackage

// File: rtl/nvram_upload_reader_if.sv
// data_io upload signals plus the CMOS RAM read port and core write strobe.
interface nvram_upload_reader_if #(
  parameter int ADDR_W = 8
);
  logic              ioctl_upl;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              din_valid;
  logic [ADDR_W-1:0] cmos_addr;
  logic              cmos_rd;
  logic [7:0]        cmos_q;
  logic              cpu_cmos_we;
  logic              nvram_dirty;
  logic              upload_busy;
  logic              upload_done;

  modport slave (
    input  ioctl_upl, ioctl_index, ioctl_addr, cmos_q, cpu_cmos_we,
    output ioctl_din, din_valid, cmos_addr, cmos_rd,
           nvram_dirty, upload_busy, upload_done
  );

  modport master (
    output ioctl_upl, ioctl_index, ioctl_addr, cmos_q, cpu_cmos_we,
    input  ioctl_din, din_valid, cmos_addr, cmos_rd,
           nvram_dirty, upload_busy, upload_done
  );
endinterface

// File: rtl/nvram_dirty_tracker.sv
// Dirty flag (set beats clear) and highest-served-address tracking for save completion.
module nvram_dirty_tracker #(
  parameter int ADDR_W   = 8,
  parameter int NV_BYTES = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_set,
  input  logic              i_start,
  input  logic              i_serve,
  input  logic [ADDR_W-1:0] i_serve_addr,
  input  logic              i_close,
  output logic              o_dirty,
  output logic              o_done
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NV_BYTES - 1);

  logic [ADDR_W-1:0] r_max_seen;
  logic              r_dirty;
  logic              r_done;
  logic              w_complete;

  assign w_complete = i_close && (r_max_seen == LAST_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max_seen <= '0;
      r_dirty    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_complete;
      // A CPU write in the completion clock must survive the clear.
      if (i_set)
        r_dirty <= 1'b1;
      else if (w_complete)
        r_dirty <= 1'b0;
      if (i_start)
        r_max_seen <= '0;
      else if (i_serve && (i_serve_addr > r_max_seen))
        r_max_seen <= i_serve_addr;
    end
  end

  assign o_dirty = r_dirty;
  assign o_done  = r_done;

endmodule

// File: rtl/nvram_upload_reader.sv
// Serves CMOS NVRAM bytes to data_io on upload, one fetch per address change.
module nvram_upload_reader
  import nvram_pkg::*;
#(
  parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT,
  parameter int         NV_BYTES = 256,
  parameter int         ADDR_W   = 8,
  parameter int         RAM_LAT  = 1
) (
  input logic                  clk_sys,
  input logic                  reset_n,
  nvram_upload_reader_if.slave bus
);
  nv_state_t         r_state;
  logic              r_sel_q;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_over;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_over;
  logic [ADDR_W-1:0] r_cmos_addr;
  logic              r_cmos_rd;
  logic [7:0]        r_din;
  logic              r_din_valid;
  logic [1:0]        r_wait_cnt;

  logic              w_sel;
  logic              w_sel_rise;
  logic              w_sel_fall;
  logic              w_over;
  logic [ADDR_W-1:0] w_addr_lo;
  logic              w_addr_new;
  logic              w_req_match;
  logic              w_start;
  logic              w_abort;
  logic              w_serve;
  logic              w_dirty;
  logic              w_done;

  assign w_sel       = bus.ioctl_upl && (bus.ioctl_index == NV_INDEX);
  assign w_sel_rise  = w_sel && !r_sel_q;
  assign w_sel_fall  = !w_sel && r_sel_q;
  assign w_over      = (bus.ioctl_addr >= 25'(NV_BYTES));
  assign w_addr_lo   = bus.ioctl_addr[ADDR_W-1:0];
  assign w_addr_new  = (w_addr_lo != r_last_addr) || (w_over != r_last_over);
  assign w_req_match = (w_addr_lo == r_req_addr) && (w_over == r_req_over);
  assign w_abort     = (r_state != IDLE) && !w_sel;
  assign w_start     = ((r_state == IDLE) && w_sel_rise) ||
                       ((r_state == HOLD) && w_sel && w_addr_new);
  assign w_serve     = (r_state == WAIT) && (r_wait_cnt == 2'd0) && w_sel;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sel_q     <= 1'b0;
      r_req_addr  <= '0;
      r_req_over  <= 1'b0;
      r_last_addr <= '0;
      r_last_over <= 1'b0;
      r_cmos_addr <= '0;
      r_cmos_rd   <= 1'b0;
      r_din       <= 8'h00;
      r_din_valid <= 1'b0;
      r_wait_cnt  <= 2'd0;
    end else begin
      r_sel_q <= w_sel;
      if (w_abort) begin
        r_state     <= IDLE;
        r_cmos_rd   <= 1'b0;
        r_din_valid <= 1'b0;
      end else if (w_start) begin
        // The read strobe is issued on entry so FETCH is the strobe clock.
        r_state     <= FETCH;
        r_req_addr  <= w_addr_lo;
        r_req_over  <= w_over;
        r_cmos_rd   <= !w_over;
        r_din_valid <= 1'b0;
        if (!w_over)
          r_cmos_addr <= w_addr_lo;
      end else begin
        case (r_state)
          FETCH: begin
            r_cmos_rd <= 1'b0;
            if (r_req_over) begin
              r_din       <= NV_FILL;
              r_din_valid <= w_req_match;
              r_last_addr <= r_req_addr;
              r_last_over <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_wait_cnt <= 2'(RAM_LAT - 1);
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (r_wait_cnt == 2'd0) begin
              // Withhold valid if the host moved on; HOLD will re-fetch.
              r_din       <= bus.cmos_q;
              r_din_valid <= w_req_match;
              r_last_addr <= r_req_addr;
              r_last_over <= 1'b0;
              r_state     <= HOLD;
            end else begin
              r_wait_cnt <= r_wait_cnt - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  nvram_dirty_tracker #(
    .ADDR_W   (ADDR_W),
    .NV_BYTES (NV_BYTES)
  ) u_tracker (
    .i_clk        (clk_sys),
    .i_rst_n      (reset_n),
    .i_set        (bus.cpu_cmos_we),
    .i_start      (w_sel_rise),
    .i_serve      (w_serve),
    .i_serve_addr (r_req_addr),
    .i_close      (w_sel_fall),
    .o_dirty      (w_dirty),
    .o_done       (w_done)
  );

  assign bus.ioctl_din   = r_din;
  assign bus.din_valid   = r_din_valid;
  assign bus.cmos_addr   = r_cmos_addr;
  assign bus.cmos_rd     = r_cmos_rd;
  assign bus.nvram_dirty = w_dirty;
  assign bus.upload_busy = (r_state != IDLE);
  assign bus.upload_done = w_done;

endmodule
